iob_axil2iob: RTL and testbench

IOB_AXIL2IOB -- requirements
Module: iob_axil2iob

---
 rtl/iob_axil2iob.sv | 221 ++++++++++++++++++++++
 tb/tb_iob_axil2iob.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iob_axil2iob.sv
// iob_axil2iob: AXI4-Lite slave to IOb master bridge.
//
// Accepts one AXI4-Lite transaction at a time and converts it into a single
// IOb access. Writes need both AW and W (in any order) before the IOb write
// is issued. A write with an all-zero strobe completes without touching IOb,
// because wstrb=0 means "read" on IOb. Reads issue an IOb read and return the
// data once iob_rvalid_i arrives.
//
// Ports:
//   clk_i, arst_n_i         clock, asynchronous active-low reset
//   axil_aw*/axil_w*/axil_b*  AXI4-Lite write address, write data, write response
//   axil_ar*/axil_r*        AXI4-Lite read address, read data/response
//   iob_valid_o/iob_addr_o/iob_wdata_o/iob_wstrb_o   IOb request
//   iob_ready_i             IOb request accepted
//   iob_rvalid_i/iob_rdata_i  IOb read data return
module iob_axil2iob #(
    parameter int AXIL_ADDR_W = 21,
    parameter int AXIL_DATA_W = 32,
    parameter int ADDR_W      = AXIL_ADDR_W,
    parameter int DATA_W      = AXIL_DATA_W
) (
    input  logic                     clk_i,
    input  logic                     arst_n_i,
    // AXI4-Lite write address
    input  logic                     axil_awvalid_i,
    output logic                     axil_awready_o,
    input  logic [AXIL_ADDR_W-1:0]   axil_awaddr_i,
    input  logic [2:0]               axil_awprot_i,
    // AXI4-Lite write data
    input  logic                     axil_wvalid_i,
    output logic                     axil_wready_o,
    input  logic [AXIL_DATA_W-1:0]   axil_wdata_i,
    input  logic [AXIL_DATA_W/8-1:0] axil_wstrb_i,
    // AXI4-Lite write response
    output logic                     axil_bvalid_o,
    input  logic                     axil_bready_i,
    output logic [1:0]               axil_bresp_o,
    // AXI4-Lite read address
    input  logic                     axil_arvalid_i,
    output logic                     axil_arready_o,
    input  logic [AXIL_ADDR_W-1:0]   axil_araddr_i,
    input  logic [2:0]               axil_arprot_i,
    // AXI4-Lite read data
    output logic                     axil_rvalid_o,
    input  logic                     axil_rready_i,
    output logic [AXIL_DATA_W-1:0]   axil_rdata_o,
    output logic [1:0]               axil_rresp_o,
    // IOb master
    output logic                     iob_valid_o,
    output logic [ADDR_W-1:0]        iob_addr_o,
    output logic [DATA_W-1:0]        iob_wdata_o,
    output logic [DATA_W/8-1:0]      iob_wstrb_o,
    input  logic                     iob_ready_i,
    input  logic                     iob_rvalid_i,
    input  logic [DATA_W-1:0]        iob_rdata_i
);

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        WR_RESP,
        RD_REQ,
        RD_WAIT,
        RD_RESP
    } state_t;

    state_t state, state_nxt;

    logic                     aw_cap;
    logic                     w_cap;
    logic [AXIL_ADDR_W-1:0]   addr_reg;
    logic [AXIL_DATA_W-1:0]   wdata_reg;
    logic [AXIL_DATA_W/8-1:0] wstrb_reg;
    logic [AXIL_DATA_W-1:0]   rdata_reg;

    logic aw_hs;
    logic w_hs;
    logic ar_hs;
    logic wr_done;
    logic rd_capture;

    // Protection attributes carry no meaning on IOb.
    logic unused_prot;
    assign unused_prot = ^{axil_awprot_i, axil_arprot_i};

    // Next state and handshake outputs.
    always_comb begin
        state_nxt      = state;
        axil_awready_o = 1'b0;
        axil_wready_o  = 1'b0;
        axil_arready_o = 1'b0;
        axil_bvalid_o  = 1'b0;
        axil_rvalid_o  = 1'b0;
        iob_valid_o    = 1'b0;
        iob_wstrb_o    = '0;
        aw_hs          = 1'b0;
        w_hs           = 1'b0;
        ar_hs          = 1'b0;
        wr_done        = 1'b0;
        rd_capture     = 1'b0;

        case (state)
            IDLE: begin
                axil_awready_o = !aw_cap;
                axil_wready_o  = !w_cap;
                // A pending or partially captured write blocks reads.
                axil_arready_o = !aw_cap && !w_cap && !axil_awvalid_i && !axil_wvalid_i;
                aw_hs = axil_awvalid_i && axil_awready_o;
                w_hs  = axil_wvalid_i && axil_wready_o;
                ar_hs = axil_arvalid_i && axil_arready_o;
                // Count this cycle's handshakes so AW+W together leave IDLE
                // on the same edge that captures them.
                if ((aw_cap || aw_hs) && (w_cap || w_hs)) begin
                    if ((w_hs ? axil_wstrb_i : wstrb_reg) == '0) begin
                        state_nxt = WR_RESP;
                    end else begin
                        state_nxt = WR_REQ;
                    end
                end else if (ar_hs) begin
                    state_nxt = RD_REQ;
                end
            end
            WR_REQ: begin
                iob_valid_o = 1'b1;
                iob_wstrb_o = wstrb_reg;
                if (iob_ready_i) begin
                    state_nxt = WR_RESP;
                end
            end
            WR_RESP: begin
                axil_bvalid_o = 1'b1;
                if (axil_bready_i) begin
                    wr_done   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            RD_REQ: begin
                iob_valid_o = 1'b1;
                if (iob_ready_i) begin
                    if (iob_rvalid_i) begin
                        rd_capture = 1'b1;
                        state_nxt  = RD_RESP;
                    end else begin
                        state_nxt = RD_WAIT;
                    end
                end
            end
            RD_WAIT: begin
                if (iob_rvalid_i) begin
                    rd_capture = 1'b1;
                    state_nxt  = RD_RESP;
                end
            end
            RD_RESP: begin
                axil_rvalid_o = 1'b1;
                if (axil_rready_i) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Captured request fields and read data.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            aw_cap    <= 1'b0;
            w_cap     <= 1'b0;
            addr_reg  <= '0;
            wdata_reg <= '0;
            wstrb_reg <= '0;
            rdata_reg <= '0;
        end else begin
            if (wr_done) begin
                aw_cap <= 1'b0;
                w_cap  <= 1'b0;
            end else begin
                if (aw_hs) begin
                    aw_cap <= 1'b1;
                end
                if (w_hs) begin
                    w_cap <= 1'b1;
                end
            end
            if (aw_hs) begin
                addr_reg <= axil_awaddr_i;
            end else if (ar_hs) begin
                addr_reg <= axil_araddr_i;
            end
            if (w_hs) begin
                wdata_reg <= axil_wdata_i;
                wstrb_reg <= axil_wstrb_i;
            end
            if (rd_capture) begin
                rdata_reg <= iob_rdata_i;
            end
        end
    end

    generate
        if (ADDR_W <= AXIL_ADDR_W) begin : g_addr_trunc
            assign iob_addr_o = addr_reg[ADDR_W-1:0];
        end else begin : g_addr_ext
            assign iob_addr_o = {{(ADDR_W - AXIL_ADDR_W){1'b0}}, addr_reg};
        end
    endgenerate

    assign iob_wdata_o  = wdata_reg;
    assign axil_rdata_o = rdata_reg;
    assign axil_bresp_o = 2'b00;
    assign axil_rresp_o = 2'b00;

endmodule

// File: tb/tb_iob_axil2iob.sv
// Self-checking bench for iob_axil2iob: directed latency/priority/reset cases
// followed by randomized read/write transactions with random channel delays.
module tb_iob_axil2iob;

    localparam int unsigned BOUND = 200;

    logic        clk_i;
    logic        arst_n_i;
    logic        axil_awvalid_i;
    logic        axil_awready_o;
    logic [20:0] axil_awaddr_i;
    logic [2:0]  axil_awprot_i;
    logic        axil_wvalid_i;
    logic        axil_wready_o;
    logic [31:0] axil_wdata_i;
    logic [3:0]  axil_wstrb_i;
    logic        axil_bvalid_o;
    logic        axil_bready_i;
    logic [1:0]  axil_bresp_o;
    logic        axil_arvalid_i;
    logic        axil_arready_o;
    logic [20:0] axil_araddr_i;
    logic [2:0]  axil_arprot_i;
    logic        axil_rvalid_o;
    logic        axil_rready_i;
    logic [31:0] axil_rdata_o;
    logic [1:0]  axil_rresp_o;
    logic        iob_valid_o;
    logic [20:0] iob_addr_o;
    logic [31:0] iob_wdata_o;
    logic [3:0]  iob_wstrb_o;
    logic        iob_ready_i;
    logic        iob_rvalid_i;
    logic [31:0] iob_rdata_i;

    iob_axil2iob #(
        .AXIL_ADDR_W(21),
        .AXIL_DATA_W(32)
    ) dut (
        .clk_i         (clk_i),
        .arst_n_i      (arst_n_i),
        .axil_awvalid_i(axil_awvalid_i),
        .axil_awready_o(axil_awready_o),
        .axil_awaddr_i (axil_awaddr_i),
        .axil_awprot_i (axil_awprot_i),
        .axil_wvalid_i (axil_wvalid_i),
        .axil_wready_o (axil_wready_o),
        .axil_wdata_i  (axil_wdata_i),
        .axil_wstrb_i  (axil_wstrb_i),
        .axil_bvalid_o (axil_bvalid_o),
        .axil_bready_i (axil_bready_i),
        .axil_bresp_o  (axil_bresp_o),
        .axil_arvalid_i(axil_arvalid_i),
        .axil_arready_o(axil_arready_o),
        .axil_araddr_i (axil_araddr_i),
        .axil_arprot_i (axil_arprot_i),
        .axil_rvalid_o (axil_rvalid_o),
        .axil_rready_i (axil_rready_i),
        .axil_rdata_o  (axil_rdata_o),
        .axil_rresp_o  (axil_rresp_o),
        .iob_valid_o   (iob_valid_o),
        .iob_addr_o    (iob_addr_o),
        .iob_wdata_o   (iob_wdata_o),
        .iob_wstrb_o   (iob_wstrb_o),
        .iob_ready_i   (iob_ready_i),
        .iob_rvalid_i  (iob_rvalid_i),
        .iob_rdata_i   (iob_rdata_i)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    int unsigned cyc = 0;
    int unsigned iob_hs_cnt = 0;
    int unsigned exp_iob_hs = 0;
    int unsigned last_b_cyc = 0;

    // Per-transaction handshake bookkeeping shared between forked branches.
    bit          aw_done_g, w_done_g, ar_done_g;
    int unsigned aw_cyc_g, w_cyc_g, ar_cyc_g;

    always @(posedge clk_i) cyc <= cyc + 1;

    // Count IOb handshakes midway through the low phase, after the slave drives ready.
    always @(negedge clk_i) begin
        #2;
        if (iob_valid_o && iob_ready_i) iob_hs_cnt++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    function automatic int unsigned umax(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    task automatic axil_write(input logic [20:0] addr, input logic [31:0] data,
                              input logic [3:0] strb, input int unsigned aw_dly,
                              input int unsigned w_dly, input int unsigned rdy_dly,
                              input int unsigned b_dly);
        aw_done_g = 1'b0;
        w_done_g  = 1'b0;
        fork
            begin : aw_chan
                int unsigned n;
                repeat (aw_dly) tick();
                axil_awvalid_i = 1'b1;
                axil_awaddr_i  = addr;
                axil_awprot_i  = 3'($urandom);
                n = 0;
                @(negedge clk_i);
                while (!axil_awready_o && n < BOUND) begin
                    @(negedge clk_i);
                    n++;
                end
                check("aw_accept_wait", 64'(n), 64'd0);
                aw_cyc_g  = cyc;
                aw_done_g = 1'b1;
                tick();
                axil_awvalid_i = 1'b0;
                axil_awaddr_i  = 21'($urandom);
            end
            begin : w_chan
                int unsigned n;
                repeat (w_dly) tick();
                axil_wvalid_i = 1'b1;
                axil_wdata_i  = data;
                axil_wstrb_i  = strb;
                n = 0;
                @(negedge clk_i);
                while (!axil_wready_o && n < BOUND) begin
                    @(negedge clk_i);
                    n++;
                end
                check("w_accept_wait", 64'(n), 64'd0);
                w_cyc_g  = cyc;
                w_done_g = 1'b1;
                tick();
                axil_wvalid_i = 1'b0;
                axil_wdata_i  = $urandom;
                axil_wstrb_i  = 4'($urandom);
            end
            begin : iob_slave
                int unsigned n;
                wait (aw_done_g && w_done_g);
                @(negedge clk_i);
                if (strb != 4'd0) begin
                    n = 0;
                    while (!iob_valid_o && n < BOUND) begin
                        @(negedge clk_i);
                        n++;
                    end
                    check("iob_wr_start_cyc", 64'(cyc), 64'(umax(aw_cyc_g, w_cyc_g) + 1));
                    check("iob_wr_addr", 64'(iob_addr_o), 64'(addr));
                    check("iob_wr_data", 64'(iob_wdata_o), 64'(data));
                    check("iob_wr_strb", 64'(iob_wstrb_o), 64'(strb));
                    repeat (rdy_dly) @(negedge clk_i);
                    check("iob_wr_hold", 64'(iob_valid_o), 64'd1);
                    iob_ready_i = 1'b1;
                    exp_iob_hs++;
                    tick();
                    iob_ready_i = 1'b0;
                end else begin
                    check("iob_idle_strb0", 64'(iob_valid_o), 64'd0);
                end
            end
            begin : b_chan
                int unsigned n;
                int unsigned exp_cyc;
                wait (aw_done_g && w_done_g);
                n = 0;
                @(negedge clk_i);
                while (!axil_bvalid_o && n < BOUND) begin
                    @(negedge clk_i);
                    n++;
                end
                exp_cyc = umax(aw_cyc_g, w_cyc_g) + ((strb != 4'd0) ? (2 + rdy_dly) : 1);
                check("b_latency", 64'(cyc), 64'(exp_cyc));
                check("b_resp", 64'(axil_bresp_o), 64'd0);
                repeat (b_dly) @(negedge clk_i);
                check("b_hold", 64'(axil_bvalid_o), 64'd1);
                axil_bready_i = 1'b1;
                last_b_cyc = cyc;
                tick();
                axil_bready_i = 1'b0;
            end
        join
        check("iob_count_wr", 64'(iob_hs_cnt), 64'(exp_iob_hs));
    endtask

    task automatic axil_read(input logic [20:0] addr, input logic [31:0] rdata,
                             input int unsigned rdy_dly, input int unsigned rv_dly,
                             input int unsigned r_dly, input bit after_write);
        ar_done_g = 1'b0;
        fork
            begin : ar_chan
                int unsigned n;
                axil_arvalid_i = 1'b1;
                axil_araddr_i  = addr;
                axil_arprot_i  = 3'($urandom);
                n = 0;
                @(negedge clk_i);
                while (!axil_arready_o && n < BOUND) begin
                    @(negedge clk_i);
                    n++;
                end
                if (after_write) check("ar_after_b_cyc", 64'(cyc), 64'(last_b_cyc + 1));
                else check("ar_accept_wait", 64'(n), 64'd0);
                ar_cyc_g  = cyc;
                ar_done_g = 1'b1;
                tick();
                axil_arvalid_i = 1'b0;
                axil_araddr_i  = 21'($urandom);
            end
            begin : iob_slave
                int unsigned n;
                wait (ar_done_g);
                n = 0;
                @(negedge clk_i);
                while (!iob_valid_o && n < BOUND) begin
                    @(negedge clk_i);
                    n++;
                end
                check("iob_rd_start_cyc", 64'(cyc), 64'(ar_cyc_g + 1));
                check("iob_rd_addr", 64'(iob_addr_o), 64'(addr));
                check("iob_rd_wstrb", 64'(iob_wstrb_o), 64'd0);
                repeat (rdy_dly) @(negedge clk_i);
                check("iob_rd_hold", 64'(iob_valid_o), 64'd1);
                iob_ready_i = 1'b1;
                exp_iob_hs++;
                if (rv_dly == 0) begin
                    iob_rvalid_i = 1'b1;
                    iob_rdata_i  = rdata;
                end
                tick();
                iob_ready_i  = 1'b0;
                iob_rvalid_i = 1'b0;
                iob_rdata_i  = $urandom;
                if (rv_dly != 0) begin
                    repeat (rv_dly) @(negedge clk_i);
                    iob_rvalid_i = 1'b1;
                    iob_rdata_i  = rdata;
                    tick();
                    iob_rvalid_i = 1'b0;
                    iob_rdata_i  = $urandom;
                end
            end
            begin : r_chan
                int unsigned n;
                wait (ar_done_g);
                n = 0;
                @(negedge clk_i);
                while (!axil_rvalid_o && n < BOUND) begin
                    @(negedge clk_i);
                    n++;
                end
                check("r_latency", 64'(cyc), 64'(ar_cyc_g + 2 + rdy_dly + rv_dly));
                check("r_data", 64'(axil_rdata_o), 64'(rdata));
                check("r_resp", 64'(axil_rresp_o), 64'd0);
                repeat (r_dly) @(negedge clk_i);
                check("r_hold_valid", 64'(axil_rvalid_o), 64'd1);
                check("r_hold_data", 64'(axil_rdata_o), 64'(rdata));
                axil_rready_i = 1'b1;
                tick();
                axil_rready_i = 1'b0;
            end
        join
        check("iob_count_rd", 64'(iob_hs_cnt), 64'(exp_iob_hs));
    endtask

    task automatic reset_mid_read();
        axil_arvalid_i = 1'b1;
        axil_araddr_i  = 21'h155;
        @(negedge clk_i);
        check("rst_ar_ready", 64'(axil_arready_o), 64'd1);
        tick();
        axil_arvalid_i = 1'b0;
        @(negedge clk_i);
        check("rst_iob_rd_valid", 64'(iob_valid_o), 64'd1);
        iob_ready_i = 1'b1;
        exp_iob_hs++;
        tick();
        iob_ready_i = 1'b0;
        @(negedge clk_i);
        check("rst_wait_iob_valid", 64'(iob_valid_o), 64'd0);
        #1 arst_n_i = 1'b0;
        #1;
        check("rst_async_rvalid", 64'(axil_rvalid_o), 64'd0);
        check("rst_async_iob_valid", 64'(iob_valid_o), 64'd0);
        check("rst_async_awready", 64'(axil_awready_o), 64'd1);
        check("rst_async_rdata", 64'(axil_rdata_o), 64'd0);
        tick();
        arst_n_i     = 1'b1;
        iob_rvalid_i = 1'b1;
        iob_rdata_i  = 32'hBAD0BAD0;
        @(negedge clk_i);
        check("rst_rel_awready", 64'(axil_awready_o), 64'd1);
        check("rst_rel_wready", 64'(axil_wready_o), 64'd1);
        tick();
        iob_rvalid_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            check("rst_late_rvalid", 64'(axil_rvalid_o), 64'd0);
            check("rst_late_bvalid", 64'(axil_bvalid_o), 64'd0);
        end
        check("iob_count_rst", 64'(iob_hs_cnt), 64'(exp_iob_hs));
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        arst_n_i       = 1'b0;
        axil_awvalid_i = 1'b0;
        axil_awaddr_i  = '0;
        axil_awprot_i  = '0;
        axil_wvalid_i  = 1'b0;
        axil_wdata_i   = '0;
        axil_wstrb_i   = '0;
        axil_bready_i  = 1'b0;
        axil_arvalid_i = 1'b0;
        axil_araddr_i  = '0;
        axil_arprot_i  = '0;
        axil_rready_i  = 1'b0;
        iob_ready_i    = 1'b0;
        iob_rvalid_i   = 1'b0;
        iob_rdata_i    = '0;

        #1;
        check("rst_awready", 64'(axil_awready_o), 64'd1);
        check("rst_wready", 64'(axil_wready_o), 64'd1);
        check("rst_arready", 64'(axil_arready_o), 64'd1);
        check("rst_bvalid", 64'(axil_bvalid_o), 64'd0);
        check("rst_rvalid", 64'(axil_rvalid_o), 64'd0);
        check("rst_iob_valid", 64'(iob_valid_o), 64'd0);
        check("rst_iob_addr", 64'(iob_addr_o), 64'd0);
        check("rst_iob_wdata", 64'(iob_wdata_o), 64'd0);
        check("rst_iob_wstrb", 64'(iob_wstrb_o), 64'd0);
        check("rst_rdata", 64'(axil_rdata_o), 64'd0);

        repeat (3) tick();
        arst_n_i = 1'b1;
        tick();

        // Same-cycle AW+W, zero-wait IOb.
        axil_write(21'h10, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0);
        // W first, AW three cycles later.
        axil_write(21'h24, 32'h0BADF00D, 4'h5, 3, 0, 0, 0);
        // Read with IOb ready after 2 waits, rvalid a cycle later, rready held off 3 cycles.
        axil_read(21'h20, 32'h12345678, 2, 1, 3, 1'b0);
        // Read with rvalid alongside ready.
        axil_read(21'h1FFFFF, 32'hA5A5A5A5, 0, 0, 0, 1'b0);
        // Zero-strobe write completes with no IOb access.
        axil_write(21'h30, 32'h11112222, 4'h0, 0, 0, 0, 0);
        axil_write(21'h34, 32'h33334444, 4'h0, 0, 2, 0, 1);
        // Simultaneous write and read: write first.
        fork
            axil_write(21'h44, 32'h87654321, 4'hF, 0, 0, 1, 0);
            axil_read(21'h88, 32'hCAFEF00D, 0, 0, 0, 1'b1);
        join
        // Reset during RD_WAIT.
        reset_mid_read();
        check("post_rst_rdata", 64'(axil_rdata_o), 64'd0);

        for (int t = 0; t < 60; t++) begin
            logic [20:0] a;
            logic [31:0] d;
            logic [3:0]  s;
            a = 21'($urandom);
            d = $urandom;
            s = ($urandom_range(0, 4) == 0) ? 4'h0 : 4'($urandom);
            if ($urandom_range(0, 1) == 0) begin
                axil_write(a, d, s, $urandom_range(0, 3), $urandom_range(0, 3),
                           $urandom_range(0, 3), $urandom_range(0, 3));
            end else begin
                axil_read(a, d, $urandom_range(0, 3), $urandom_range(0, 2),
                          $urandom_range(0, 3), 1'b0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
